// File: rtl/dafx_pkg.sv
// Shared constants and types for the DAFX sample-capture block.
// Defaults describe a 3-channel, 24-bit stream captured at 10 kHz from a 125 MHz clock.
package dafx_pkg;

    localparam int AUDIO_WIDTH_C          = 24;
    localparam int NR_OF_CHANNELS_C       = 3;
    localparam int SAMPLING_IRQ_COUNTER_C = 12500;
    localparam int FIFO_FRAMES_C          = 16;

    typedef enum logic {
        WR_IDLE  = 1'b0,
        WR_WRITE = 1'b1
    } wr_state_e;

    // Width of a word counter that must be able to hold the value 'words' itself.
    function automatic int level_width(input int words);
        return $clog2(words) + 1;
    endfunction

endpackage

// File: rtl/dafx_sample_capture_if.sv
// Bundles for the sample-capture block: the internal storage bus between the
// capture logic and its FIFO, and the host-side control/status/audio bundle.
interface dafx_fifo_if #(
    parameter int WIDTH_P   = 24,
    parameter int LEVEL_W_P = 6
);
    logic                 clear;
    logic                 wr_en;
    logic [WIDTH_P-1:0]   wr_data;
    logic                 rd_en;
    logic [WIDTH_P-1:0]   rd_data;
    logic [LEVEL_W_P-1:0] level;

    modport master (output clear, wr_en, wr_data, rd_en, input rd_data, level);
    modport slave  (input clear, wr_en, wr_data, rd_en, output rd_data, level);
endinterface

interface dafx_sample_capture_if #(
    parameter int AUDIO_WIDTH_P    = 24,
    parameter int NR_OF_CHANNELS_P = 3,
    parameter int LEVEL_W_P        = 6
);
    logic                                      enable;
    logic                                      fifo_clear;
    logic                                      audio_valid;
    logic [NR_OF_CHANNELS_P*AUDIO_WIDTH_P-1:0] audio_data;
    logic                                      rd_en;
    logic [AUDIO_WIDTH_P-1:0]                  rd_data;
    logic                                      rd_valid;
    logic                                      irq_ack;
    logic                                      irq;
    logic [LEVEL_W_P-1:0]                      fifo_level;
    logic                                      overflow;
    logic                                      underflow;

    // master is the host/audio side, slave is the capture block.
    modport master (output enable, fifo_clear, audio_valid, audio_data, rd_en, irq_ack,
                    input  rd_data, rd_valid, irq, fifo_level, overflow, underflow);
    modport slave  (input  enable, fifo_clear, audio_valid, audio_data, rd_en, irq_ack,
                    output rd_data, rd_valid, irq, fifo_level, overflow, underflow);
endinterface

// File: rtl/dafx_sample_fifo.sv
// Single-clock sample FIFO with registered (1-cycle) read data.
// The master guarantees it never pushes when full nor pops when empty.
module dafx_sample_fifo
    import dafx_pkg::*;
#(
    parameter int WIDTH_P = AUDIO_WIDTH_C,
    parameter int DEPTH_P = FIFO_FRAMES_C * NR_OF_CHANNELS_C
) (
    input  logic      clk,
    input  logic      rst_n,
    dafx_fifo_if.slave bus
);

    localparam int PTR_W_C   = (DEPTH_P > 1) ? $clog2(DEPTH_P) : 1;
    localparam int LEVEL_W_C = level_width(DEPTH_P);

    logic [WIDTH_P-1:0]   mem_q [DEPTH_P];
    logic [PTR_W_C-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W_C-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LEVEL_W_C-1:0] level_q, level_d;
    logic [WIDTH_P-1:0]   rd_data_q, rd_data_d;

    // Depth need not be a power of two, so pointers wrap explicitly.
    function automatic logic [PTR_W_C-1:0] ptr_inc(input logic [PTR_W_C-1:0] p);
        return (p == PTR_W_C'(DEPTH_P - 1)) ? '0 : p + 1'b1;
    endfunction

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        level_d   = level_q;
        rd_data_d = rd_data_q;
        if (bus.clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (bus.wr_en) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (bus.rd_en) begin
                rd_ptr_d  = ptr_inc(rd_ptr_q);
                rd_data_d = mem_q[rd_ptr_q];
            end
            case ({bus.wr_en, bus.rd_en})
                2'b10:   level_d = level_q + 1'b1;
                2'b01:   level_d = level_q - 1'b1;
                default: level_d = level_q;
            endcase
        end
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            rd_data_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            rd_data_q <= rd_data_d;
        end
    end

    // NOTE: the storage array has no reset; the pointers and level already make it empty.
    always_ff @(posedge clk) begin
        if (bus.wr_en && !bus.clear) begin
            mem_q[wr_ptr_q] <= bus.wr_data;
        end
    end

    assign bus.level   = level_q;
    assign bus.rd_data = rd_data_q;

endmodule

// File: rtl/dafx_sample_capture.sv
// Captures a multi-channel audio frame on every sampling tick into a FIFO
// (whole frames only) and serves single-word host reads with an interrupt.
module dafx_sample_capture
    import dafx_pkg::*;
#(
    parameter int AUDIO_WIDTH_P    = AUDIO_WIDTH_C,
    parameter int NR_OF_CHANNELS_P = NR_OF_CHANNELS_C,
    parameter int IRQ_COUNTER_P    = SAMPLING_IRQ_COUNTER_C,
    parameter int FIFO_FRAMES_P    = FIFO_FRAMES_C
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      cr_enable,
    input  logic                                      cr_fifo_clear,
    input  logic                                      x_audio_valid,
    input  logic [NR_OF_CHANNELS_P*AUDIO_WIDTH_P-1:0] x_audio_data,
    input  logic                                      host_rd_en,
    output logic [AUDIO_WIDTH_P-1:0]                  host_rd_data,
    output logic                                      host_rd_valid,
    input  logic                                      host_irq_ack,
    output logic                                      irq,
    output logic [$clog2(FIFO_FRAMES_P*NR_OF_CHANNELS_P):0] sr_fifo_level,
    output logic                                      sr_overflow,
    output logic                                      sr_underflow
);

    localparam int FIFO_WORDS_C = FIFO_FRAMES_P * NR_OF_CHANNELS_P;
    localparam int LEVEL_W_C    = level_width(FIFO_WORDS_C);
    localparam int CNT_W_C      = (IRQ_COUNTER_P > 1) ? $clog2(IRQ_COUNTER_P) : 1;
    localparam int IDX_W_C      = (NR_OF_CHANNELS_P > 1) ? $clog2(NR_OF_CHANNELS_P) : 1;
    localparam int FRAME_W_C    = NR_OF_CHANNELS_P * AUDIO_WIDTH_P;

    dafx_fifo_if #(.WIDTH_P(AUDIO_WIDTH_P), .LEVEL_W_P(LEVEL_W_C)) fifo_bus ();

    logic [CNT_W_C-1:0]       cnt_q, cnt_d;
    logic                     tick;
    wr_state_e                state_q, state_d;
    logic [IDX_W_C-1:0]       idx_q;
    logic [FRAME_W_C-1:0]     frame_q, snap_q;
    logic                     room_ok;
    logic                     push, last_push, pop, drop, rd_empty;
    logic [AUDIO_WIDTH_P-1:0] push_data;
    logic                     irq_q, overflow_q, underflow_q, rd_valid_q;

    // Tick counter: held at zero while disabled, tick on the wrap cycle.
    always_comb begin
        cnt_d = cnt_q;
        if (!cr_enable) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_W_C'(IRQ_COUNTER_P - 1)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign tick     = cr_enable && (cnt_q == CNT_W_C'(IRQ_COUNTER_P - 1));
    assign room_ok  = fifo_bus.level <= LEVEL_W_C'(FIFO_WORDS_C - NR_OF_CHANNELS_P);
    assign rd_empty = (fifo_bus.level == '0);

    // Write FSM: state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= WR_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Write FSM: next state. A flush always aborts an in-flight frame.
    always_comb begin
        state_d = state_q;
        case (state_q)
            WR_IDLE:  if (tick && room_ok) state_d = WR_WRITE;
            WR_WRITE: if (idx_q == IDX_W_C'(NR_OF_CHANNELS_P - 1)) state_d = WR_IDLE;
            default:  state_d = WR_IDLE;
        endcase
        if (cr_fifo_clear) begin
            state_d = WR_IDLE;
        end
    end

    // Write FSM: outputs.
    always_comb begin
        push      = (state_q == WR_WRITE) && !cr_fifo_clear;
        last_push = push && (idx_q == IDX_W_C'(NR_OF_CHANNELS_P - 1));
        drop      = (state_q == WR_IDLE) && tick && !room_ok && !cr_fifo_clear;
        push_data = snap_q[idx_q*AUDIO_WIDTH_P +: AUDIO_WIDTH_P];
    end

    assign pop = host_rd_en && !rd_empty && !cr_fifo_clear;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            frame_q <= '0;
            snap_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (x_audio_valid) begin
                frame_q <= x_audio_data;
            end
            // Snapshot decouples the pushed frame from new audio arriving mid-write.
            if (state_q == WR_IDLE && state_d == WR_WRITE) begin
                snap_q <= frame_q;
            end
            if (push && !last_push) begin
                idx_q <= idx_q + 1'b1;
            end else begin
                idx_q <= '0;
            end
        end
    end

    // Status flags; a flush wins over any set in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_q       <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            rd_valid_q  <= 1'b0;
        end else begin
            rd_valid_q <= pop;
            if (cr_fifo_clear) begin
                irq_q       <= 1'b0;
                overflow_q  <= 1'b0;
                underflow_q <= 1'b0;
            end else begin
                if (last_push) begin
                    irq_q <= 1'b1;
                end else if (host_irq_ack) begin
                    irq_q <= 1'b0;
                end
                if (drop) begin
                    overflow_q <= 1'b1;
                end
                if (host_rd_en && rd_empty) begin
                    underflow_q <= 1'b1;
                end
            end
        end
    end

    assign fifo_bus.clear   = cr_fifo_clear;
    assign fifo_bus.wr_en   = push;
    assign fifo_bus.wr_data = push_data;
    assign fifo_bus.rd_en   = pop;

    dafx_sample_fifo #(
        .WIDTH_P (AUDIO_WIDTH_P),
        .DEPTH_P (FIFO_WORDS_C)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (fifo_bus)
    );

    assign host_rd_data  = fifo_bus.rd_data;
    assign host_rd_valid = rd_valid_q;
    assign irq           = irq_q;
    assign sr_fifo_level = fifo_bus.level;
    assign sr_overflow   = overflow_q;
    assign sr_underflow  = underflow_q;

endmodule

// File: tb/tb_dafx_sample_capture.sv
// Directed scoreboard bench for dafx_sample_capture with a 20-cycle tick,
// 3 channels and a 2-frame (6-word) FIFO.
module tb_dafx_sample_capture;

    localparam int AW    = 24;
    localparam int CH    = 3;
    localparam int IRQ_N = 20;
    localparam int FR    = 2;
    localparam int LW    = $clog2(FR*CH) + 1;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    logic [AW-1:0] exp_q [$];

    dafx_sample_capture_if #(.AUDIO_WIDTH_P(AW), .NR_OF_CHANNELS_P(CH), .LEVEL_W_P(LW)) hb ();

    dafx_sample_capture #(
        .AUDIO_WIDTH_P    (AW),
        .NR_OF_CHANNELS_P (CH),
        .IRQ_COUNTER_P    (IRQ_N),
        .FIFO_FRAMES_P    (FR)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cr_enable     (hb.enable),
        .cr_fifo_clear (hb.fifo_clear),
        .x_audio_valid (hb.audio_valid),
        .x_audio_data  (hb.audio_data),
        .host_rd_en    (hb.rd_en),
        .host_rd_data  (hb.rd_data),
        .host_rd_valid (hb.rd_valid),
        .host_irq_ack  (hb.irq_ack),
        .irq           (hb.irq),
        .sr_fifo_level (hb.fifo_level),
        .sr_overflow   (hb.overflow),
        .sr_underflow  (hb.underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500us;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Loads the frame register and records the words it should yield, channel 0 first.
    task automatic load_frame(input logic [AW-1:0] c0, input logic [AW-1:0] c1,
                              input logic [AW-1:0] c2, input bit expect_stored);
        hb.audio_valid = 1'b1;
        hb.audio_data  = {c2, c1, c0};
        step(1);
        hb.audio_valid = 1'b0;
        if (expect_stored) begin
            exp_q.push_back(c0);
            exp_q.push_back(c1);
            exp_q.push_back(c2);
        end
    endtask

    task automatic wait_level(input int target, input int budget, input string tag);
        for (int i = 0; i < budget; i++) begin
            if (hb.fifo_level == LW'(target)) break;
            step(1);
        end
        check(tag, 32'(hb.fifo_level), 32'(target));
    endtask

    task automatic read_words(input int n, input string tag);
        logic [AW-1:0] exp_w;
        for (int i = 0; i < n; i++) begin
            hb.rd_en = 1'b1;
            step(1);
            check({tag, "_valid"}, 32'(hb.rd_valid), 32'd1);
            exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : 24'hBAD_BAD;
            check({tag, "_data"}, 32'(hb.rd_data), 32'(exp_w));
        end
        hb.rd_en = 1'b0;
    endtask

    initial begin
        int n;
        total = 0;
        bad   = 0;
        rst_n          = 1'b0;
        hb.enable      = 1'b0;
        hb.fifo_clear  = 1'b0;
        hb.audio_valid = 1'b0;
        hb.audio_data  = '0;
        hb.rd_en       = 1'b0;
        hb.irq_ack     = 1'b0;
        step(3);
        check("rst_level",     32'(hb.fifo_level), 32'd0);
        check("rst_irq",       32'(hb.irq),        32'd0);
        check("rst_rd_valid",  32'(hb.rd_valid),   32'd0);
        check("rst_rd_data",   32'(hb.rd_data),    32'd0);
        check("rst_overflow",  32'(hb.overflow),   32'd0);
        check("rst_underflow", 32'(hb.underflow),  32'd0);
        rst_n = 1'b1;
        step(1);

        // Basic capture: tick after IRQ_N edges, first push one edge later.
        load_frame(24'h000001, 24'h000002, 24'h000003, 1'b1);
        hb.enable = 1'b1;
        n = 0;
        while (hb.fifo_level == '0 && n < 40) begin
            step(1);
            n++;
        end
        check("first_push_cycle", 32'(n), 32'(IRQ_N + 1));
        check("lvl_step1", 32'(hb.fifo_level), 32'd1);
        check("irq_step1", 32'(hb.irq), 32'd0);
        step(1);
        check("lvl_step2", 32'(hb.fifo_level), 32'd2);
        check("irq_step2", 32'(hb.irq), 32'd0);
        step(1);
        check("lvl_step3", 32'(hb.fifo_level), 32'd3);
        check("irq_step3", 32'(hb.irq), 32'd1);
        hb.enable = 1'b0;
        read_words(3, "rd_basic");
        check("lvl_after_basic", 32'(hb.fifo_level), 32'd0);
        step(1);
        check("valid_idle", 32'(hb.rd_valid), 32'd0);
        hb.irq_ack = 1'b1;
        step(1);
        hb.irq_ack = 1'b0;
        check("irq_acked", 32'(hb.irq), 32'd0);

        // Underflow: read from empty FIFO, then flush clears it.
        hb.rd_en = 1'b1;
        step(1);
        hb.rd_en = 1'b0;
        check("uf_valid",     32'(hb.rd_valid),  32'd0);
        check("uf_flag",      32'(hb.underflow), 32'd1);
        check("uf_data_hold", 32'(hb.rd_data),   32'h000003);
        hb.fifo_clear = 1'b1;
        step(1);
        hb.fifo_clear = 1'b0;
        check("uf_cleared", 32'(hb.underflow), 32'd0);

        // Overflow: two frames fill the FIFO, the third is dropped whole.
        load_frame(24'h0000A0, 24'h0000A1, 24'h0000A2, 1'b1);
        hb.enable = 1'b1;
        wait_level(3, 30, "ovf_first_frame");
        load_frame(24'h0000B0, 24'h0000B1, 24'h0000B2, 1'b1);
        wait_level(6, 30, "ovf_second_frame");
        check("ovf_not_yet", 32'(hb.overflow), 32'd0);
        load_frame(24'h0000C0, 24'h0000C1, 24'h0000C2, 1'b0);
        step(25);
        check("ovf_flag",  32'(hb.overflow),   32'd1);
        check("ovf_level", 32'(hb.fifo_level), 32'd6);
        hb.enable = 1'b0;
        read_words(6, "rd_ovf");
        check("ovf_sticky", 32'(hb.overflow), 32'd1);
        hb.fifo_clear = 1'b1;
        step(1);
        hb.fifo_clear = 1'b0;
        check("ovf_cleared", 32'(hb.overflow), 32'd0);
        check("irq_cleared", 32'(hb.irq),      32'd0);

        // Ack coincident with last push keeps irq; enable drop mid-write completes frame.
        exp_q.push_back(24'h0000C0);
        exp_q.push_back(24'h0000C1);
        exp_q.push_back(24'h0000C2);
        hb.enable = 1'b1;
        wait_level(2, 30, "ack_mid_frame");
        hb.enable  = 1'b0;
        hb.irq_ack = 1'b1;
        step(1);
        hb.irq_ack = 1'b0;
        check("ack_same_cycle_lvl", 32'(hb.fifo_level), 32'd3);
        check("ack_same_cycle_irq", 32'(hb.irq), 32'd1);
        step(1);
        check("irq_held", 32'(hb.irq), 32'd1);
        hb.irq_ack = 1'b1;
        step(1);
        hb.irq_ack = 1'b0;
        check("irq_later_ack", 32'(hb.irq), 32'd0);
        read_words(3, "rd_ack");

        // Simultaneous push and pop: level holds, order preserved, snapshot isolated.
        load_frame(24'h0000D0, 24'h0000D1, 24'h0000D2, 1'b1);
        hb.enable = 1'b1;
        wait_level(3, 30, "pp_prefill");
        load_frame(24'h0000E0, 24'h0000E1, 24'h0000E2, 1'b1);
        step(IRQ_N - 4);
        for (int i = 0; i < CH; i++) begin
            hb.rd_en       = 1'b1;
            hb.audio_valid = (i == 0);
            hb.audio_data  = {CH{24'hFFFFFF}};
            step(1);
            hb.audio_valid = 1'b0;
            check("pp_level", 32'(hb.fifo_level), 32'd3);
            check("pp_valid", 32'(hb.rd_valid), 32'd1);
            check("pp_data",  32'(hb.rd_data), 32'(exp_q.size() > 0 ? exp_q.pop_front() : 24'hBAD_BAD));
        end
        hb.rd_en  = 1'b0;
        hb.enable = 1'b0;
        read_words(3, "rd_pp");
        check("pp_drained", 32'(hb.fifo_level), 32'd0);

        // Reset mid-write discards the partial frame; next frame stored whole.
        load_frame(24'h000F10, 24'h000F11, 24'h000F12, 1'b0);
        hb.enable = 1'b1;
        wait_level(2, 30, "rst_mid_write");
        rst_n = 1'b0;
        #1;
        check("arst_level",     32'(hb.fifo_level), 32'd0);
        check("arst_irq",       32'(hb.irq),        32'd0);
        check("arst_rd_valid",  32'(hb.rd_valid),   32'd0);
        check("arst_rd_data",   32'(hb.rd_data),    32'd0);
        check("arst_overflow",  32'(hb.overflow),   32'd0);
        check("arst_underflow", 32'(hb.underflow),  32'd0);
        hb.enable = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(1);
        load_frame(24'h000A11, 24'h000A22, 24'h000A33, 1'b1);
        hb.enable = 1'b1;
        wait_level(3, 30, "post_rst_frame");
        check("post_rst_irq", 32'(hb.irq), 32'd1);
        hb.enable = 1'b0;
        read_words(3, "rd_post_rst");
        check("post_rst_empty", 32'(hb.fifo_level), 32'd0);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dafx_sample_capture.md
DAFX_SAMPLE_CAPTURE -- requirements
Module: dafx_sample_capture

Interface
REQ-001 The block SHALL have parameter AUDIO_WIDTH_P, default 24, sample width in bits.
REQ-002 The block SHALL have parameter NR_OF_CHANNELS_P, default 3, channels per frame.
REQ-003 The block SHALL have parameter IRQ_COUNTER_P, default 12500, clk cycles per capture tick (125 MHz / 10 kHz); the legal range is IRQ_COUNTER_P > NR_OF_CHANNELS_P + 1.
REQ-004 The block SHALL have parameter FIFO_FRAMES_P, default 16, buffer depth in frames; FIFO words = FIFO_FRAMES_P*NR_OF_CHANNELS_P.
REQ-005 The block SHALL have port clk  in  1  system clock, the only clock.
REQ-006 The block SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-007 The block SHALL have port cr_enable  in  1  enables the tick counter and capture.
REQ-008 The block SHALL have port cr_fifo_clear  in  1  synchronous flush of FIFO and sticky flags.
REQ-009 The block SHALL have port x_audio_valid  in  1  new audio frame present.
REQ-010 The block SHALL have port x_audio_data  in  NR_OF_CHANNELS_P*AUDIO_WIDTH_P  frame, channel 0 in the LSBs.
REQ-011 The block SHALL have port host_rd_en  in  1  host pops one word.
REQ-012 The block SHALL have port host_rd_data  out  AUDIO_WIDTH_P  popped sample.
REQ-013 The block SHALL have port host_rd_valid  out  1  one-cycle qualifier for host_rd_data.
REQ-014 The block SHALL have port host_irq_ack  in  1  clears irq.
REQ-015 The block SHALL have port irq  out  1  frame-available interrupt, level.
REQ-016 The block SHALL have port sr_fifo_level  out  $clog2(FIFO words)+1  stored words.
REQ-017 The block SHALL have port sr_overflow  out  1  sticky: a frame was dropped.
REQ-018 The block SHALL have port sr_underflow  out  1  sticky: a read was issued while the FIFO was empty.

Function
REQ-019 The frame register SHALL load x_audio_data on every cycle with x_audio_valid=1, independent of cr_enable.
REQ-020 The tick counter SHALL count 0..IRQ_COUNTER_P-1 and wrap while cr_enable=1; cr_enable=0 SHALL hold it at 0.
REQ-021 A tick SHALL occur on the cycle the counter wraps to 0.
REQ-022 The write FSM SHALL have states IDLE and WRITE: IDLE->WRITE on a tick when free words >= NR_OF_CHANNELS_P; WRITE SHALL push one word per cycle (channel 0 first) from a snapshot of the frame register taken at the tick, then return to IDLE after NR_OF_CHANNELS_P pushes.
REQ-023 A tick with free words < NR_OF_CHANNELS_P SHALL drop the whole frame, stay in IDLE and set sr_overflow; no partial frames SHALL ever be stored.
REQ-024 A read SHALL require host_rd_en=1 with level > 0; host_rd_data and host_rd_valid=1 SHALL appear on the next cycle (latency 1); host_rd_valid SHALL otherwise be 0.
REQ-025 host_rd_en=1 with level = 0 SHALL set sr_underflow; host_rd_valid SHALL stay 0 and host_rd_data SHALL hold its value.
REQ-026 A push and a pop in the same cycle SHALL both complete, leaving the level unchanged; the pointers SHALL wrap modulo the FIFO word count.
REQ-027 irq SHALL be set on the cycle of the last push of a frame and cleared by host_irq_ack; a set and an ack in the same cycle SHALL leave irq=1.
REQ-028 cr_fifo_clear SHALL zero the pointers, level, irq, sr_overflow and sr_underflow, abort WRITE to IDLE, and take priority over a push or pop in the same cycle.
REQ-029 Dropping cr_enable mid-WRITE SHALL let the current frame complete.

Reset
REQ-030 rst_n=0 SHALL asynchronously force counter=0, FSM=IDLE, pointers=0, frame register=0, host_rd_data=0, host_rd_valid=0, irq=0, sr_fifo_level=0, sr_overflow=0 and sr_underflow=0; reset mid-WRITE SHALL discard the partial frame.

Structure
REQ-031 dafx_pkg SHALL hold AUDIO_WIDTH_C, NR_OF_CHANNELS_C, SAMPLING_IRQ_COUNTER_C (the parameter defaults) and the FSM state enum type.
REQ-032 Storage SHALL be a sub-module named dafx_sample_fifo (single-clock, 1-cycle read latency); the counter, FSM and flags SHALL live in the top module.

Verification (IRQ_COUNTER_P=20, NR_OF_CHANNELS_P=3, FIFO_FRAMES_P=2)
REQ-033 Frame {0x000003,0x000002,0x000001} valid, enable -> first tick at cycle 20, level steps 1,2,3, irq=1 at the third push; three reads return 0x000001, 0x000002, 0x000003 each 1 cycle later.
REQ-034 No reads for 3 ticks -> level=6, third frame dropped, sr_overflow=1, level stays 6.
REQ-035 Read with level=0 -> host_rd_valid=0, sr_underflow=1; cr_fifo_clear -> sr_underflow=0.
REQ-036 host_irq_ack on the same cycle as the last push of a frame -> irq stays 1; a later ack with no new frame -> irq=0.
REQ-037 Pop on every push cycle of a frame -> level constant, data order preserved.
REQ-038 rst_n low after the 2nd push -> all outputs 0 immediately; after release the next captured frame is stored complete.
